window_builder: RTL and testbench

Streaming 3x3 window generator that turns a raster-order 8-bit grayscale pixel stream into 72-bit neighbourhood windows for the noise filter stage. It sits directly upstream of `noise_filter` and drives its `img_window` input, so the HPS no longer assembles windows through three PIO registers. Two line buffers hold the previous rows, and a 3x3 register array forms each window. Valid/ready handshakes on both sides allow back-pressure from the filter.

---
 rtl/window_builder.sv | 180 ++++++++++++++++++
 tb/tb_window_builder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_builder.sv
// ============================================================================
// Module   : window_builder
// Purpose  : Streaming 3x3 window generator. Turns a raster-order 8-bit pixel
//            stream into 72-bit neighbourhood windows for noise_filter, using
//            two line buffers and a 3x3 shift-register array. Valid/ready
//            handshakes on both sides.
// Options  : `define WINDOW_BUILDER_SOF_EOF_EN adds the out_sof / out_eof
//            window markers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_builder #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int COL_W      = 9,
    parameter int ROW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_pixel,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [72:1]      img_window,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic             out_valid,
`ifdef WINDOW_BUILDER_SOF_EOF_EN
    output logic             out_sof,
    output logic             out_eof,
`endif
    input  logic             out_ready
);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);

    // Line buffers: lb1 holds the previous row, lb2 the row before that.
    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb2_mem [IMG_WIDTH];

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [23:0]      top_q, top_d;
    logic [23:0]      mid_q, mid_d;
    logic [23:0]      bot_q, bot_d;
    logic [71:0]      win_q, win_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0] orow_q, orow_d;
    logic             ovalid_q, ovalid_d;

    logic             w_accept;
    logic             w_emit;
    logic [COL_W-1:0] w_cur_col;
    logic [ROW_W-1:0] w_cur_row;
    logic [7:0]       w_lb1_rd;
    logic [7:0]       w_lb2_rd;

    // A new pixel can enter whenever the output register is free or draining.
    assign in_ready = !ovalid_q || out_ready;

    // Position, window shifting and output-register next-state logic.
    always_comb begin
        w_accept  = in_valid && in_ready;
        // in_sof relocates the accepted pixel to (0,0); rows 0/1 of the new
        // frame never emit, so stale line-buffer data is never exposed.
        w_cur_col = in_sof ? '0 : col_q;
        w_cur_row = in_sof ? '0 : row_q;
        // Reads see the contents from before this cycle's write.
        w_lb1_rd  = lb1_mem[w_cur_col];
        w_lb2_rd  = lb2_mem[w_cur_col];
        w_emit    = w_accept && (w_cur_col >= c_col_two) && (w_cur_row >= c_row_two);

        col_d    = col_q;
        row_d    = row_q;
        top_d    = top_q;
        mid_d    = mid_q;
        bot_d    = bot_q;
        win_d    = win_q;
        ocol_d   = ocol_q;
        orow_d   = orow_q;
        ovalid_d = ovalid_q;

        if (w_accept) begin
            if (w_cur_col == c_col_last) begin
                col_d = '0;
                row_d = (w_cur_row == c_row_last) ? '0 : w_cur_row + ROW_W'(1);
            end else begin
                col_d = w_cur_col + COL_W'(1);
                row_d = w_cur_row;
            end
            top_d = {top_q[15:0], w_lb2_rd};
            mid_d = {mid_q[15:0], w_lb1_rd};
            bot_d = {bot_q[15:0], in_pixel};
        end

        if (w_emit) begin
            // Leftmost pixel lands in the most significant byte of each row.
            win_d    = {top_q[15:0], w_lb2_rd, mid_q[15:0], w_lb1_rd, bot_q[15:0], in_pixel};
            ocol_d   = w_cur_col - COL_W'(1);
            orow_d   = w_cur_row - ROW_W'(1);
            ovalid_d = 1'b1;
        end else if (out_ready) begin
            ovalid_d = 1'b0;
        end
    end

    // Line buffer storage: no reset, contents only matter after two new rows.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb2_mem[w_cur_col] <= lb1_mem[w_cur_col];
            lb1_mem[w_cur_col] <= in_pixel;
        end
    end

    // Counters, window array and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            top_q    <= '0;
            mid_q    <= '0;
            bot_q    <= '0;
            win_q    <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            top_q    <= top_d;
            mid_q    <= mid_d;
            bot_q    <= bot_d;
            win_q    <= win_d;
            ocol_q   <= ocol_d;
            orow_q   <= orow_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign img_window = win_q;
    assign out_col    = ocol_q;
    assign out_row    = orow_q;
    assign out_valid  = ovalid_q;

`ifdef WINDOW_BUILDER_SOF_EOF_EN
    logic sof_q, sof_d;
    logic eof_q, eof_d;

    // Frame markers travel with the window they describe.
    always_comb begin
        sof_d = sof_q;
        eof_d = eof_q;
        if (w_emit) begin
            sof_d = (w_cur_col == c_col_two)  && (w_cur_row == c_row_two);
            eof_d = (w_cur_col == c_col_last) && (w_cur_row == c_row_last);
        end
    end

    // Frame marker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sof_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            sof_q <= sof_d;
            eof_q <= eof_d;
        end
    end

    assign out_sof = sof_q;
    assign out_eof = eof_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_window_builder.sv
`default_nettype none

module tb_window_builder;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [71:0] win;
        logic [1:0]  col;
        logic [1:0]  row;
        logic        sof;
        logic        eof;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_pixel = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [72:1] img_window;
    logic [1:0]  out_col;
    logic [1:0]  out_row;
    logic        out_valid;
    logic        out_sof_s;
    logic        out_eof_s;

    int checks = 0;
    int failures = 0;

    rec_t tbl [4];
    rec_t capq [$];
    rec_t mon_c;

    always #5 clk = ~clk;

    window_builder #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (2),
        .ROW_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .img_window(img_window),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_valid (out_valid),
`ifdef WINDOW_BUILDER_SOF_EOF_EN
        .out_sof   (out_sof_s),
        .out_eof   (out_eof_s),
`endif
        .out_ready (out_ready)
    );

`ifndef WINDOW_BUILDER_SOF_EOF_EN
    assign out_sof_s = 1'b0;
    assign out_eof_s = 1'b0;
`endif

    // Record every window that is handed over downstream.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            mon_c.win = img_window;
            mon_c.col = out_col;
            mon_c.row = out_row;
            mon_c.sof = out_sof_s;
            mon_c.eof = out_eof_s;
            capq.push_back(mon_c);
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        in_pixel = p;
        in_sof   = sof;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept pixel=%h", p);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic sof_first);
        for (int i = 0; i < W * H; i++)
            send_pixel(base + 8'(i), sof_first && (i == 0));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare captured windows against the table; frame k uses its own base.
    task automatic check_frames(input int n, input logic [7:0] base0, input logic [7:0] base1);
        logic [7:0] b;
        chk("win_count", 72'(capq.size()), 72'(n));
        for (int i = 0; i < n && i < capq.size(); i++) begin
            b = (i < 4) ? base0 : base1;
            chk($sformatf("win%0d_data", i), capq[i].win, tbl[i % 4].win | {9{b}});
            chk($sformatf("win%0d_col", i), 72'(capq[i].col), 72'(tbl[i % 4].col));
            chk($sformatf("win%0d_row", i), 72'(capq[i].row), 72'(tbl[i % 4].row));
`ifdef WINDOW_BUILDER_SOF_EOF_EN
            chk($sformatf("win%0d_sof", i), 72'(capq[i].sof), 72'((i % 4) == 0));
            chk($sformatf("win%0d_eof", i), 72'(capq[i].eof), 72'((i % 4) == 3));
`endif
        end
        capq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected windows for a 4x4 frame of pixels 0..15, centre order.
        tbl[0] = '{72'h00_01_02_04_05_06_08_09_0A, 2'd1, 2'd1, 1'b1, 1'b0};
        tbl[1] = '{72'h01_02_03_05_06_07_09_0A_0B, 2'd2, 2'd1, 1'b0, 1'b0};
        tbl[2] = '{72'h04_05_06_08_09_0A_0C_0D_0E, 2'd1, 2'd2, 1'b0, 1'b0};
        tbl[3] = '{72'h05_06_07_09_0A_0B_0D_0E_0F, 2'd2, 2'd2, 1'b0, 1'b1};

        // Reset state.
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        chk("rst_img_window", img_window, 72'h0);
        chk("rst_out_col", 72'(out_col), 72'(0));
        chk("rst_out_row", 72'(out_row), 72'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 1: basic frame, with an in_sof that must be ignored
        // because no transfer happens on that cycle.
        for (int i = 0; i < 6; i++) send_pixel(8'(i), i == 0);
        in_sof = 1'b1;
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        for (int i = 6; i < 11; i++) send_pixel(8'(i), 1'b0);
        chk("lat_out_valid", 72'(out_valid), 72'(1));
        chk("lat_out_col", 72'(out_col), 72'(1));
        chk("lat_out_row", 72'(out_row), 72'(1));
        for (int i = 11; i < 16; i++) send_pixel(8'(i), 1'b0);
        wait_cycles(3);
        chk("s1_drained", 72'(out_valid), 72'(0));
        check_frames(4, 8'h00, 8'h00);

        // Scenario 2: back-pressure for 5 cycles after the first window.
        fork
            send_frame(8'h00, 1'b1);
            begin
                int n;
                n = 0;
                while (!out_valid && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("s2_first_window_seen", 72'(out_valid), 72'(1));
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk($sformatf("s2_stall%0d_in_ready", k), 72'(in_ready), 72'(0));
                    chk($sformatf("s2_stall%0d_hold", k), img_window, tbl[0].win);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_cycles(3);
        check_frames(4, 8'h00, 8'h00);

        // Scenario 3: in_sof on the 7th pixel restarts the frame.
        for (int i = 0; i < 6; i++) send_pixel(8'hE0 + 8'(i), i == 0);
        send_frame(8'h40, 1'b1);
        wait_cycles(3);
        check_frames(4, 8'h40, 8'h40);

        // Scenario 4: asynchronous reset mid-frame with a window held.
        for (int i = 0; i < 11; i++) send_pixel(8'(i), i == 0);
        out_ready = 1'b0;
        chk("s4_pre_reset_valid", 72'(out_valid), 72'(1));
        #3;
        reset = 1'b1;
        #1;
        chk("s4_rst_out_valid", 72'(out_valid), 72'(0));
        chk("s4_rst_img_window", img_window, 72'h0);
        chk("s4_rst_out_col", 72'(out_col), 72'(0));
        chk("s4_rst_out_row", 72'(out_row), 72'(0));
        chk("s4_rst_in_ready", 72'(in_ready), 72'(1));
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        capq.delete();
        @(posedge clk);
        #1;
        send_frame(8'h00, 1'b0);
        wait_cycles(3);
        check_frames(4, 8'h00, 8'h00);

        // Scenario 5: two frames back to back with no idle cycles.
        send_frame(8'h00, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_cycles(3);
        check_frames(8, 8'h00, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
